// File: rtl/gpr_operand_fetch.sv
// Operand-fetch stage in front of the dual-port register file: 1-cycle registered reads,
// valid/ready hand-off to execute, and the single writeback path with operand bypass.
module gpr_operand_fetch #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iIssValid,
    output logic          oIssReady,
    input  logic [AW-1:0] iSrcA,
    input  logic [AW-1:0] iSrcB,
    input  logic          iUseA,
    input  logic          iUseB,
    input  logic          iWbValid,
    output logic          oWbReady,
    input  logic [AW-1:0] iWbAddr,
    input  logic [DW-1:0] iWbData,
    output logic [AW-1:0] oAddrA,
    output logic [DW-1:0] oDInA,
    output logic          oWriteA,
    input  logic [DW-1:0] iDOutA,
    output logic [AW-1:0] oAddrB,
    output logic [DW-1:0] oDInB,
    output logic          oWriteB,
    input  logic [DW-1:0] iDOutB,
    output logic          oOpValid,
    input  logic          iOpReady,
    output logic [DW-1:0] oOpA,
    output logic [DW-1:0] oOpB
);

    typedef enum logic [1:0] {StIdle, StRead, StCapt, StOut} stateE;

    stateE         state;
    logic [AW-1:0] srcA, srcB;
    logic          useA, useB;
    logic [DW-1:0] opA, opB;

    logic issAccept, wbAccept, hitA, hitB;

    assign oIssReady = (state == StIdle) || ((state == StOut) && iOpReady);
    assign issAccept = iIssValid && oIssReady;

    // Port A is shared with the writeback, so writes are held off while the read is in flight.
    assign oWbReady  = (state != StRead);
    assign wbAccept  = iWbValid && oWbReady;

    assign oAddrA    = wbAccept ? iWbAddr : srcA;
    assign oDInA     = wbAccept ? iWbData : '0;
    assign oWriteA   = wbAccept;
    assign oAddrB    = srcB;
    assign oDInB     = '0;
    assign oWriteB   = 1'b0;

    assign hitA      = wbAccept && useA && (iWbAddr == srcA);
    assign hitB      = wbAccept && useB && (iWbAddr == srcB);

    assign oOpValid  = (state == StOut);
    assign oOpA      = opA;
    assign oOpB      = opB;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= StIdle;
            srcA  <= '0;
            srcB  <= '0;
            useA  <= 1'b0;
            useB  <= 1'b0;
            opA   <= '0;
            opB   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (issAccept) state <= StRead;
                end
                StRead: state <= StCapt;
                StCapt: begin
                    state <= StOut;
                    opA   <= useA ? (hitA ? iWbData : iDOutA) : '0;
                    opB   <= useB ? (hitB ? iWbData : iDOutB) : '0;
                end
                StOut: begin
                    // Held operands track later writebacks until execute takes them.
                    if (hitA) opA <= iWbData;
                    if (hitB) opB <= iWbData;
                    if (iOpReady) state <= issAccept ? StRead : StIdle;
                end
            endcase
            if (issAccept) begin
                srcA <= iSrcA;
                srcB <= iSrcB;
                useA <= iUseA;
                useB <= iUseB;
            end
        end
    end

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Bench for gpr_operand_fetch: register-file model on the ports, architectural register
// state plus issue-age tracking as the reference.
module tb_gpr_operand_fetch;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstN;
    logic          issValid, issReady;
    logic [AW-1:0] srcA, srcB;
    logic          useA, useB;
    logic          wbValid, wbReady;
    logic [AW-1:0] wbAddr;
    logic [DW-1:0] wbData;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dInA, dInB, doutA, doutB;
    logic          writeA, writeB;
    logic          opValid, opReady;
    logic [DW-1:0] opA, opB;

    always #5 clk = ~clk;

    gpr_operand_fetch #(.DW(DW), .AW(AW)) dut (
        .iClk(clk), .iRst(rstN),
        .iIssValid(issValid), .oIssReady(issReady),
        .iSrcA(srcA), .iSrcB(srcB), .iUseA(useA), .iUseB(useB),
        .iWbValid(wbValid), .oWbReady(wbReady), .iWbAddr(wbAddr), .iWbData(wbData),
        .oAddrA(addrA), .oDInA(dInA), .oWriteA(writeA), .iDOutA(doutA),
        .oAddrB(addrB), .oDInB(dInB), .oWriteB(writeB), .iDOutB(doutB),
        .oOpValid(opValid), .iOpReady(opReady), .oOpA(opA), .oOpB(opB)
    );

    // Dual-port register file with registered read data.
    logic [DW-1:0] rf [64];
    always @(posedge clk) begin
        if (writeA) rf[addrA] <= dInA;
        doutA <= rf[addrA];
        doutB <= rf[addrB];
    end

    // Reference: architectural register values and one outstanding fetch with its age.
    logic [DW-1:0] golden [64];
    bit            busy;
    int            age;
    logic [AW-1:0] mSrcA, mSrcB;
    bit            mUseA, mUseB;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational and held outputs, advance the model.
    task automatic cycle(input bit iv, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input bit ua, input bit ub, input bit wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input bit rdy);
        bit expValid, expIss, expWb, accIss;
        issValid = iv; srcA = a; srcB = b; useA = ua; useB = ub;
        wbValid = wv; wbAddr = wa; wbData = wd; opReady = rdy;
        #1;
        expValid = busy && (age == 3);
        expIss   = !busy || (expValid && rdy);
        expWb    = !(busy && (age == 1));
        check("issReady", DW'(issReady), DW'(expIss));
        check("wbReady", DW'(wbReady), DW'(expWb));
        check("writeA", DW'(writeA), DW'(wv && expWb));
        check("writeB", DW'(writeB), '0);
        check("dInB", dInB, '0);
        check("opValid", DW'(opValid), DW'(expValid));
        if (wv && expWb) begin
            check("wbAddr", DW'(addrA), DW'(wa));
            check("wbData", dInA, wd);
        end
        if (busy && (age == 1)) begin
            check("rdAddrA", DW'(addrA), DW'(mSrcA));
            check("rdAddrB", DW'(addrB), DW'(mSrcB));
        end
        if (expValid) begin
            check("opA", opA, mUseA ? golden[mSrcA] : '0);
            check("opB", opB, mUseB ? golden[mSrcB] : '0);
        end
        accIss = iv && expIss;
        @(posedge clk);
        if (wv && expWb) golden[wa] = wd;
        if (busy) begin
            if (age < 3) age++;
            else if (rdy) busy = 0;
        end
        if (accIss) begin
            busy = 1; age = 1;
            mSrcA = a; mSrcB = b; mUseA = ua; mUseB = ub;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cycle(0, '0, '0, 0, 0, 0, '0, '0, rdy);
    endtask

    task automatic wb(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        cycle(0, '0, '0, 0, 0, 1, wa, wd, 0);
    endtask

    initial begin
        busy = 0; age = 0; mSrcA = '0; mSrcB = '0; mUseA = 0; mUseB = 0;
        issValid = 0; srcA = '0; srcB = '0; useA = 0; useB = 0;
        wbValid = 0; wbAddr = '0; wbData = '0; opReady = 0;
        rstN = 0;
        repeat (2) @(negedge clk);
        check("rstOpValid", DW'(opValid), '0);
        check("rstOpA", opA, '0);
        check("rstOpB", opB, '0);
        check("rstIssReady", DW'(issReady), 32'd1);
        rstN = 1;

        // Fill every register through the writeback path.
        for (int i = 0; i < 64; i++) wb(AW'(i), $urandom);

        // Basic fetch, 3-cycle latency.
        wb(6'd5, 32'h1234);
        wb(6'd9, 32'hBEEF);
        cycle(1, 6'd5, 6'd9, 1, 1, 0, '0, '0, 0);
        idle(0);
        idle(0);
        check("t2OpA", opA, 32'h1234);
        check("t2OpB", opB, 32'hBEEF);
        idle(1);

        // Writeback stalled during READ, accepted the next cycle.
        cycle(1, 6'd1, 6'd2, 1, 1, 0, '0, '0, 0);
        cycle(0, '0, '0, 0, 0, 1, 6'd3, 32'h33, 0);
        cycle(0, '0, '0, 0, 0, 1, 6'd3, 32'h33, 0);
        idle(1);
        cycle(1, 6'd3, 6'd0, 1, 0, 0, '0, '0, 0);
        idle(0);
        idle(0);
        check("t3OpA", opA, 32'h33);
        idle(1);

        // Bypass in CAPT and during an OUT stall.
        wb(6'd7, 32'h1);
        cycle(1, 6'd7, 6'd0, 1, 0, 0, '0, '0, 0);
        idle(0);
        cycle(0, '0, '0, 0, 0, 1, 6'd7, 32'h55, 0);
        check("t4CaptBypass", opA, 32'h55);
        cycle(0, '0, '0, 0, 0, 1, 6'd7, 32'h66, 0);
        check("t4OutBypass", opA, 32'h66);
        idle(1);

        // Unused operand stays zero, even when its register is written.
        wb(6'd3, 32'h77);
        cycle(1, 6'd7, 6'd3, 1, 0, 0, '0, '0, 0);
        idle(0);
        idle(0);
        cycle(0, '0, '0, 0, 0, 1, 6'd3, 32'h99, 0);
        check("t5OpB", opB, '0);
        idle(1);

        // Long stall with a pending issue, then back-to-back handoff.
        cycle(1, 6'd5, 6'd9, 1, 1, 0, '0, '0, 0);
        idle(0);
        idle(0);
        repeat (4) cycle(1, 6'd9, 6'd5, 1, 1, 0, '0, '0, 0);
        check("t6OpA", opA, 32'h1234);
        check("t6OpB", opB, 32'hBEEF);
        cycle(1, 6'd9, 6'd5, 1, 1, 0, '0, '0, 1);
        cycle(0, '0, '0, 0, 0, 1, 6'd9, 32'hAA, 0);
        idle(0);
        check("t6NextOpA", opA, 32'hBEEF);
        idle(1);

        // Asynchronous reset in the middle of a READ.
        cycle(1, 6'd5, 6'd9, 1, 1, 0, '0, '0, 0);
        issValid = 0;
        rstN = 0;
        #1;
        check("t1OpValid", DW'(opValid), '0);
        check("t1OpA", opA, '0);
        check("t1IssReady", DW'(issReady), 32'd1);
        busy = 0; age = 0;
        @(negedge clk);
        rstN = 1;
        idle(0);

        // Randomized traffic, addresses kept in a small window to provoke bypass hits.
        repeat (600) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end
        repeat (4) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
